wb_slave_standard: RTL and testbench
====================================

// Module: wb_slave_standard
// PURPOSE
//   Wishbone classic ("standard") single-access slave with a registered-ack
//   synchronous memory. Connects to a Wishbone master through an if_wb
//   interface instance (slave modport). It serves single read and write
//   cycles, one data beat per cycle; it is the memory-target block for
//   the standard-master test environment.
// PARAMETERS
//   adr_width  16  address bus width; memory depth = 2**adr_width words
//   dat_width  16  data bus width = memory word width
// PORTS
//   clk        in   1          system clock, rising-edge active
//   rst        in   1          asynchronous, active-high reset
//   wb.adr     in   adr_width  word address
//   wb.dat_i   in   dat_width  write data (master -> slave)
//   wb.dat_o   out  dat_width  read data (slave -> master)
//   wb.we      in   1          1 = write, 0 = read
//   wb.cyc     in   1          bus cycle in progress
//   wb.stb     in   1          strobe / valid transfer request
//   wb.ack     out  1          transfer acknowledge
//   (wb is the if_wb interface port carrying the signals above)
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (rst).
//   - Reset: ack=0 and dat_o=0 immediately on rst assertion; they stay 0
//     while rst=1. Memory contents are not reset (undefined until written).
//   - req = cyc & stb. No request (cyc=0 or stb=0): ack=0, no memory access.
//     stb=1 with cyc=0 is ignored.
//   - Ack generation, registered: ack_next = req & ~ack.
//     * ack rises exactly one clock after req is first sampled high
//       (1 wait state).
//     * ack is high for exactly one clock per transfer.
//     * If the master keeps req high after the ack cycle, the next transfer
//       is acked two clocks after the previous ack (ack toggles 0/1).
//       So back-to-back requests are served at one beat per 2 clocks.
//   - Write: on the edge where ack_next=1 and we=1, mem[adr] <= dat_i.
//     Exactly one write per acked transfer; no write while ack=1.
//   - Read: on the edge where ack_next=1 and we=0, dat_o <= mem[adr].
//     dat_o is valid while ack=1 and holds its value until the next read.
//   - Read-after-write to the same address in the next transfer returns
//     the newly written data.
//   - adr, we and dat_i are sampled only on the ack_next edge. Master
//     changes outside that edge have no effect.
//   - Master dropping req mid-transfer (before ack): no ack, no write, and
//     the transfer is abandoned.
//   - Reset mid-transfer: ack drops asynchronously and a pending write is
//     not performed. After rst is released, the slave is idle and responds
//     to the next req normally.
//   - All addresses 0 .. 2**adr_width-1 are valid; there is no err/rty.
// TESTING
//   1. Reset held 3 clks, then idle inputs -> ack=0, dat_o=0 throughout.
//   2. Single writes: adr=1..10, dat_i=101..110, one idle clk between
//      transfers -> each ack one clk after req, 1 clk wide.
//   3. Single reads: adr=1..10 -> dat_o=101..110 in the matching ack cycle.
//   4. Back-to-back writes: adr=11..20, dat_i=211..220, with reads 11..20
//      also back-to-back -> reads return 211..220; acks alternate 1/0 and
//      there are no duplicate writes.
//   5. Protocol checks: stb=1/cyc=0 -> no ack and mem unchanged. req
//      dropped before ack -> no write (re-read gives the old value).
//   6. rst asserted asynchronously during a write with ack_next pending
//      -> ack=0 at once and the target word is unchanged. After release,
//      a normal write then read of adr=5, 0xBEEF -> 0xBEEF.

Source files
------------

// File: rtl/wb_slave_standard_if.sv
// Wishbone classic bus bundle shared by a master and the standard slave.
interface if_wb #(
    parameter int adr_width = 16,
    parameter int dat_width = 16
);
    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] dat_i;
    logic [dat_width-1:0] dat_o;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;

    modport slave  (input  adr, dat_i, we, cyc, stb, output dat_o, ack);
    modport master (output adr, dat_i, we, cyc, stb, input  dat_o, ack);
endinterface

// File: rtl/wb_slave_standard.sv
// Wishbone classic single-access slave backed by a synchronous memory.
// Every transfer gets one wait state: ack is registered from req & ~ack,
// so a held request is served at one beat every two clocks.
module wb_slave_standard #(
    parameter int adr_width = 16,
    parameter int dat_width = 16
) (
    input logic  clk,
    input logic  rst,
    if_wb.slave  wb
);
    localparam int DEPTH = 2 ** adr_width;

    logic [dat_width-1:0] mem_q [DEPTH];
    logic [dat_width-1:0] dat_o_q;
    logic                 ack_q;
    logic                 ack_d;
    logic                 req;

    // A stb without cyc is not a request.
    assign req   = wb.cyc & wb.stb;
    // Low for the cycle after an ack so that a held request is not
    // re-served on the very next edge.
    assign ack_d = req & ~ack_q;

    // Ack and read-data registers; both cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            ack_q <= ack_d;
            if (ack_d && !wb.we)
                dat_o_q <= mem_q[wb.adr];
        end
    end

    // Memory write on the acking edge only; a reset that is held across the
    // edge cancels the pending write. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (!rst && ack_d && wb.we)
            mem_q[wb.adr] <= wb.dat_i;
    end

    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_o_q;
endmodule

// File: tb/tb_wb_slave_standard.sv
// Scoreboard bench for the Wishbone standard slave: the stimulus process
// pushes the expected result of every transfer, a monitor pops on each ack.
module tb_wb_slave_standard;
    logic clk = 1'b0;
    logic rst = 1'b1;

    if_wb #(.adr_width(16), .dat_width(16)) bus ();

    wb_slave_standard #(.adr_width(16), .dat_width(16)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] adr;
        logic [15:0] dat;
    } exp_t;

    exp_t              sbq[$];
    logic [15:0]       model[int];
    logic [15:0]       written[$];
    int                checks = 0;
    int                errors = 0;
    bit                req_high = 1'b0;
    bit                prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack) begin
                exp_t e;
                chk("ack_width", {31'b0, prev_ack}, 32'd0);
                chk("ack_expected", {31'b0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    if (!e.we)
                        chk($sformatf("rd_data[%h]", e.adr), {16'b0, bus.dat_o}, {16'b0, e.dat});
                end
            end
            prev_ack = bus.ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.cyc  = 1'b0;
        bus.stb  = 1'b0;
        req_high = 1'b0;
    endtask

    // One transfer; if the request was still held from the previous one the
    // ack comes two clocks later, otherwise one.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [15:0] d);
        int   n;
        int   lat;
        exp_t e;
        lat = req_high ? 2 : 1;
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1;
        bus.we  = w;    bus.adr = a; bus.dat_i = d;
        req_high = 1'b1;
        e.we = w; e.adr = a;
        if (w) begin
            e.dat = d;
            if (!model.exists(int'(a))) written.push_back(a);
            model[int'(a)] = d;
        end else begin
            e.dat = model.exists(int'(a)) ? model[int'(a)] : 16'hxxxx;
        end
        sbq.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.ack && n < 6);
        chk($sformatf("ack_latency[%h]", a), n, lat);
    endtask

    initial begin
        logic [15:0] a;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0;   bus.dat_i = '0;

        // 1. reset and idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", {31'b0, bus.ack}, 32'd0);
            chk("rst_dat", {16'b0, bus.dat_o}, 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ack", {31'b0, bus.ack}, 32'd0);
            chk("idle_dat", {16'b0, bus.dat_o}, 32'd0);
        end

        // 2. single writes, 3. single reads
        for (int i = 1; i <= 10; i++) begin
            xfer(1'b1, 16'(i), 16'(100 + i)); idle();
        end
        for (int i = 1; i <= 10; i++) begin
            xfer(1'b0, 16'(i), 16'h0); idle();
        end

        // 4. back-to-back writes then reads
        for (int i = 11; i <= 20; i++) xfer(1'b1, 16'(i), 16'(200 + i));
        idle();
        for (int i = 11; i <= 20; i++) xfer(1'b0, 16'(i), 16'h0);
        idle();

        // 5a. stb without cyc is ignored
        @(negedge clk);
        bus.cyc = 1'b0; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 16'd1; bus.dat_i = 16'hDEAD;
        repeat (3) @(negedge clk);
        bus.stb = 1'b0;
        xfer(1'b0, 16'd1, 16'h0); idle();

        // 5b. request dropped before any sampling edge
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 16'd2; bus.dat_i = 16'hDEAD;
        #2;
        bus.cyc = 1'b0; bus.stb = 1'b0;
        repeat (2) @(negedge clk);
        xfer(1'b0, 16'd2, 16'h0); idle();

        // 6a. reset while ack is high drops it at once
        xfer(1'b0, 16'd4, 16'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ack", {31'b0, bus.ack}, 32'd0);
        chk("async_dat", {16'b0, bus.dat_o}, 32'd0);
        bus.cyc = 1'b0; bus.stb = 1'b0; req_high = 1'b0;
        @(negedge clk); rst = 1'b0;

        // 6b. reset with a write pending across the edge: write cancelled
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 16'd3; bus.dat_i = 16'hDEAD;
        #2 rst = 1'b1;
        #1 chk("rst_pend_ack", {31'b0, bus.ack}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.cyc = 1'b0; bus.stb = 1'b0;
        rst = 1'b0;
        xfer(1'b0, 16'd3, 16'h0); idle();
        xfer(1'b1, 16'd5, 16'hBEEF); idle();
        xfer(1'b0, 16'd5, 16'h0); idle();

        // randomized mix of reads/writes, single and back-to-back
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) idle();
            if ($urandom_range(0, 2) == 0 || written.size() == 0) begin
                a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
                xfer(1'b1, a, 16'($urandom));
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                xfer(1'b0, a, 16'($urandom));
            end
        end
        idle();
        repeat (4) @(negedge clk);
        chk("sb_drain", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
